// File: rtl/ifmap_stream_sender_if.sv
// SRAM read port and PE IFmap write stream for ifmap_stream_sender.
// The master side is the sender. The slave side holds the buffer SRAM and the PE.
interface ifmap_stream_sender_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  mem_ren;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_dout;
    logic [DATA_WIDTH+1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output mem_ren,
        output mem_addr,
        input  mem_dout,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  mem_ren,
        input  mem_addr,
        output mem_dout,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/ifmap_stream_sender.sv
// IFmap stream sender.
// Walks a row_len x num_rows window of a synchronous-read buffer SRAM, row by row.
// Each word goes to the PE over valid/ready, tagged {start_of_row, end_of_row, payload}.
// Every word takes FETCH -> LATCH -> SEND, so words are at least 3 cycles apart.
module ifmap_stream_sender #(
    parameter int DATA_WIDTH = 8,
    parameter int CONFIG_BIT = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] row_stride,
    input  logic [CONFIG_BIT-1:0] row_len,
    input  logic [CONFIG_BIT-1:0] num_rows,
    output logic                  busy,
    output logic                  done,
    ifmap_stream_sender_if.master bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LATCH = 3'd2;
    localparam logic [2:0] SEND  = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;

    localparam logic [CONFIG_BIT-1:0] CNT_ONE = {{(CONFIG_BIT-1){1'b0}}, 1'b1};

    logic [2:0]            state;
    logic [2:0]            state_nxt;

    // Job configuration, frozen on the edge that accepts go
    logic [ADDR_WIDTH-1:0] cfg_stride;
    logic [CONFIG_BIT-1:0] cfg_row_len;
    logic [CONFIG_BIT-1:0] cfg_num_rows;

    // Walk position
    logic [ADDR_WIDTH-1:0] row_base;
    logic [CONFIG_BIT-1:0] col;
    logic [CONFIG_BIT-1:0] row;

    logic [DATA_WIDTH+1:0] out_data_q;

    logic                  last_col;
    logic                  last_row;
    logic                  empty_job;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] rd_addr;

    assign last_col  = (col == (cfg_row_len - CNT_ONE));
    assign last_row  = (row == (cfg_num_rows - CNT_ONE));
    assign empty_job = (row_len == '0) || (num_rows == '0);
    assign xfer      = (state == SEND) && bus.out_ready;
    assign rd_addr   = row_base + {{(ADDR_WIDTH-CONFIG_BIT){1'b0}}, col};

    // Next-state selection; go is only looked at in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = empty_job ? FIN : FETCH;
                end
            end
            FETCH: state_nxt = LATCH;
            LATCH: state_nxt = SEND;
            SEND: begin
                if (bus.out_ready) begin
                    state_nxt = (last_col && last_row) ? FIN : FETCH;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts any job in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Config capture, walk counters, and the output word register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_stride   <= '0;
            cfg_row_len  <= '0;
            cfg_num_rows <= '0;
            row_base     <= '0;
            col          <= '0;
            row          <= '0;
            out_data_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        cfg_stride   <= row_stride;
                        cfg_row_len  <= row_len;
                        cfg_num_rows <= num_rows;
                        row_base     <= base_addr;
                        col          <= '0;
                        row          <= '0;
                    end
                end
                LATCH: begin
                    // The SRAM returns the word read in FETCH during this cycle
                    out_data_q <= {(col == '0), last_col, bus.mem_dout};
                end
                SEND: begin
                    if (xfer && !(last_col && last_row)) begin
                        if (last_col) begin
                            col      <= '0;
                            row      <= row + CNT_ONE;
                            row_base <= row_base + cfg_stride;
                        end else begin
                            col <= col + CNT_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // All outputs are decoded from registered state, so out_ready never reaches out_valid combinationally
    assign bus.mem_ren   = (state == FETCH);
    assign bus.mem_addr  = (state == FETCH) ? rd_addr : '0;
    assign bus.out_valid = (state == SEND);
    assign bus.out_data  = out_data_q;
    assign busy          = (state != IDLE);
    assign done          = (state == FIN);

endmodule
